// File: rtl/min_search_pipe.sv
// rtl/min_search_pipe.sv - pipelined argmin comparator tree over NUM_STATES metrics; MIN_SEARCH_NORM_EN adds norm_req
module min_search_pipe #(
    parameter int NUM_STATES = 8,
    parameter int METRIC_W   = 7,
    localparam int IDX_W     = $clog2(NUM_STATES)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_STATES*METRIC_W-1:0] metrics_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [IDX_W-1:0]               out_idx,
    output logic [METRIC_W-1:0]            out_min
`ifdef MIN_SEARCH_NORM_EN
    ,
    output logic                           norm_req
`endif
);

    // The whole tree moves in lockstep; it only freezes when a result is waiting unconsumed.
    logic adv;
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;

    // Level l halves the candidate count; stored index is relative to the node's subtree,
    // so it gains one bit per level (MSB = which half won).
    for (genvar l = 0; l < IDX_W; l++) begin : lvl
        localparam int NODES = NUM_STATES >> (l + 1);

        logic [METRIC_W-1:0] met   [NODES];
        logic [l:0]          idx   [NODES];
        logic                vld;
        logic [METRIC_W-1:0] met_d [NODES];
        logic [l:0]          idx_d [NODES];
        logic                vld_d;
        logic [NODES-1:0]    sel;

        if (l == 0) begin : g_leaf
            // First level compares adjacent raw metrics; right wins only when strictly smaller.
            always_comb begin
                vld_d = in_valid;
                for (int j = 0; j < NODES; j++) begin
                    sel[j]   = metrics_in[(2*j+1)*METRIC_W +: METRIC_W]
                             < metrics_in[(2*j)*METRIC_W +: METRIC_W];
                    met_d[j] = sel[j] ? metrics_in[(2*j+1)*METRIC_W +: METRIC_W]
                                      : metrics_in[(2*j)*METRIC_W +: METRIC_W];
                    idx_d[j] = sel[j];
                end
            end
        end else begin : g_node
            // Inner levels compare the survivors of the previous stage, ties keep the left (lower) index.
            always_comb begin
                vld_d = lvl[l-1].vld;
                for (int j = 0; j < NODES; j++) begin
                    sel[j]   = lvl[l-1].met[2*j+1] < lvl[l-1].met[2*j];
                    met_d[j] = sel[j] ? lvl[l-1].met[2*j+1] : lvl[l-1].met[2*j];
                    idx_d[j] = sel[j] ? {1'b1, lvl[l-1].idx[2*j+1]}
                                      : {1'b0, lvl[l-1].idx[2*j]};
                end
            end
        end

        // Stage register: loads on advance, otherwise holds; reset clears valid and zeroes data.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld <= 1'b0;
                for (int j = 0; j < NODES; j++) begin
                    met[j] <= '0;
                    idx[j] <= '0;
                end
            end else if (adv) begin
                vld <= vld_d;
                for (int j = 0; j < NODES; j++) begin
                    met[j] <= met_d[j];
                    idx[j] <= idx_d[j];
                end
            end
        end
    end

    assign out_valid = lvl[IDX_W-1].vld;
    assign out_min   = lvl[IDX_W-1].met[0];
    assign out_idx   = lvl[IDX_W-1].idx[0];

`ifdef MIN_SEARCH_NORM_EN
    // Flag results whose minimum has its MSB set; loaded alongside the last stage so it tracks out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            norm_req <= 1'b0;
        end else if (adv) begin
            norm_req <= lvl[IDX_W-1].vld_d && lvl[IDX_W-1].met_d[0][METRIC_W-1];
        end
    end
`endif

endmodule
